// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the MMIO data memory: I/O window offsets and decode selects.
package dmem_mmio_pkg;

    localparam logic [31:0] OFF_OUT  = 32'h0000_0000;
    localparam logic [31:0] OFF_IN   = 32'h0000_0100;
    localparam logic [31:0] OFF_FLAG = 32'h0000_0200;
    localparam logic [31:0] OFF_MASK = 32'h0000_0201;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_OUT,
        SEL_IN,
        SEL_FLAG,
        SEL_MASK,
        SEL_NONE
    } sel_e;

    // True when off lies in [base, base+n).
    function automatic logic in_window(input logic [31:0] off,
                                       input logic [31:0] base,
                                       input int unsigned n);
        return (off >= base) && (off < base + n);
    endfunction

endpackage

// File: rtl/dmem_mmio_multi_if.sv
// Core data-port bus: store strobe, word address, store data and combinational load data.
interface dmem_mmio_multi_if #(
    parameter int DATA_W = 32
);
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;

    modport master (output we, addr, wd, input rd);
    modport slave  (input we, addr, wd, output rd);
endinterface

// File: rtl/dmem_mmio_multi_in_sync_edge.sv
// One input channel: two-flop synchroniser, previous-value register and change event.
module in_sync_edge #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         evt
);
    logic [W-1:0] sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign dout = sync2_q;
    assign evt  = (sync2_q != prev_q);
endmodule

// File: rtl/dmem_mmio_multi.sv
// Data memory with an MMIO window: output registers, synchronised inputs, sticky change flags.
// Optional DMEM_FLAG_IRQ_EN adds a flag interrupt mask register and a registered irq.
module dmem_mmio_multi
    import dmem_mmio_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          AW        = 12,
    parameter int          NUM_OUT   = 2,
    parameter int          NUM_IN    = 2,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    dmem_mmio_multi_if.slave          bus,
    input  logic [NUM_IN*DATA_W-1:0]  entradas,
    output logic [NUM_OUT*DATA_W-1:0] salidas,
    output logic                      irq
);
    logic [31:0] off;
    logic        is_mmio;
    sel_e        sel;

    assign off     = bus.addr - MMIO_BASE;
    assign is_mmio = (bus.addr[31:16] == MMIO_BASE[31:16]);

    always_comb begin
        sel = SEL_RAM;
        if (is_mmio) begin
            sel = SEL_NONE;
            if (in_window(off, OFF_OUT, NUM_OUT))     sel = SEL_OUT;
            else if (in_window(off, OFF_IN, NUM_IN))  sel = SEL_IN;
            else if (off == OFF_FLAG)                 sel = SEL_FLAG;
`ifdef DMEM_FLAG_IRQ_EN
            else if (off == OFF_MASK)                 sel = SEL_MASK;
`endif
        end
    end

    // RAM: no reset, so a store coinciding with rst still lands.
    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (bus.we && sel == SEL_RAM)
            mem[bus.addr[AW-1:0]] <= bus.wd;
    end

    logic [DATA_W-1:0] out_q [NUM_OUT];
    logic [NUM_OUT-1:0] out_hit;
    logic [DATA_W-1:0] in_val [NUM_IN];
    logic [NUM_IN-1:0]  in_evt;

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
            assign out_hit[gi] = (sel == SEL_OUT) && (off == OFF_OUT + 32'(gi));
            assign salidas[gi*DATA_W +: DATA_W] = out_q[gi];
        end
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
            in_sync_edge #(.W(DATA_W)) u_sync (
                .clk  (clk),
                .rst  (rst),
                .din  (entradas[gi*DATA_W +: DATA_W]),
                .dout (in_val[gi]),
                .evt  (in_evt[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_OUT; i++) begin
            if (rst)
                out_q[i] <= '0;
            else if (bus.we && out_hit[i])
                out_q[i] <= bus.wd;
        end
    end

    // Sticky flags: a new event beats a simultaneous write-1-to-clear.
    logic [NUM_IN-1:0] flags_q, flags_d, flag_clr;

    always_comb begin
        flag_clr = '0;
        if (bus.we && sel == SEL_FLAG)
            flag_clr = bus.wd[NUM_IN-1:0];
        flags_d = (flags_q & ~flag_clr) | in_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) flags_q <= '0;
        else     flags_q <= flags_d;
    end

`ifdef DMEM_FLAG_IRQ_EN
    logic [NUM_IN-1:0] mask_q, mask_d;
    logic              irq_q;

    always_comb begin
        mask_d = mask_q;
        if (bus.we && sel == SEL_MASK)
            mask_d = bus.wd[NUM_IN-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= |(flags_d & mask_d);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    logic [DATA_W-1:0] out_rd, in_rd;

    always_comb begin
        out_rd = '0;
        for (int i = 0; i < NUM_OUT; i++)
            if (out_hit[i]) out_rd = out_q[i];
        in_rd = '0;
        for (int i = 0; i < NUM_IN; i++)
            if (off == OFF_IN + 32'(i)) in_rd = in_val[i];
    end

    always_comb begin
        bus.rd = '0;
        case (sel)
            SEL_RAM:  bus.rd = mem[bus.addr[AW-1:0]];
            SEL_OUT:  bus.rd = out_rd;
            SEL_IN:   bus.rd = in_rd;
            SEL_FLAG: bus.rd[NUM_IN-1:0] = flags_q;
`ifdef DMEM_FLAG_IRQ_EN
            SEL_MASK: bus.rd[NUM_IN-1:0] = mask_q;
`endif
            default:  bus.rd = '0;
        endcase
    end
endmodule

// File: tb/tb_dmem_mmio_multi.sv
// Directed bench for dmem_mmio_multi; expectations go into a scoreboard queue, a negedge monitor compares.
module tb_dmem_mmio_multi;
    localparam int DATA_W  = 32;
    localparam int NUM_OUT = 2;
    localparam int NUM_IN  = 2;
`ifdef DMEM_FLAG_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    localparam logic [31:0] A_OUT0 = 32'hFFFF_0000;
    localparam logic [31:0] A_OUT1 = 32'hFFFF_0001;
    localparam logic [31:0] A_IN0  = 32'hFFFF_0100;
    localparam logic [31:0] A_IN1  = 32'hFFFF_0101;
    localparam logic [31:0] A_FLAG = 32'hFFFF_0200;
    localparam logic [31:0] A_MASK = 32'hFFFF_0201;
    localparam logic [31:0] A_UNM  = 32'hFFFF_0300;

    localparam int K_RD = 0, K_SAL = 1, K_IRQ = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NUM_IN*DATA_W-1:0]  entradas = '0;
    logic [NUM_OUT*DATA_W-1:0] salidas;
    logic irq;

    dmem_mmio_multi_if #(.DATA_W(DATA_W)) bus ();

    dmem_mmio_multi #(
        .DATA_W(DATA_W), .AW(12), .NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN), .MMIO_BASE(32'hFFFF_0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .entradas (entradas),
        .salidas  (salidas),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    logic chk_valid = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t cur;
    logic [63:0] act;

    always @(negedge clk) begin
        if (chk_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty: DUT output sampled with no expectation queued");
            end else begin
                cur = sb_q.pop_front();
                case (cur.kind)
                    K_RD:    act = {32'h0, bus.rd};
                    K_SAL:   act = salidas;
                    default: act = {63'h0, irq};
                endcase
                if (act !== cur.exp) begin
                    failures++;
                    $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
                end else begin
                    $display("ok   %s: %h", cur.name, act);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.we = 1'b1; bus.addr = a; bus.wd = d;
        cyc();
        bus.we = 1'b0;
    endtask

    task automatic expect_now(input int kind, input logic [63:0] e, input string name);
        exp_t x;
        x.kind = kind; x.exp = e; x.name = name;
        sb_q.push_back(x);
        chk_valid = 1'b1;
        cyc();
        chk_valid = 1'b0;
    endtask

    task automatic ld(input logic [31:0] a, input logic [31:0] e, input string name);
        bus.we = 1'b0; bus.addr = a; bus.wd = '0;
        expect_now(K_RD, {32'h0, e}, name);
    endtask

    initial begin
        bus.we = 1'b0; bus.addr = '0; bus.wd = '0;
        repeat (3) cyc();
        rst = 1'b0;

        // Reset state
        expect_now(K_SAL, 64'h0, "reset_salidas");
        ld(A_FLAG, 32'h0, "reset_flags");
        ld(A_OUT0, 32'h0, "reset_out0");
        expect_now(K_IRQ, 64'h0, "reset_irq");

        // RAM and aliasing
        wr(32'h10, 32'hDEADBEEF);
        ld(32'h10, 32'hDEADBEEF, "ram_0x10");
        ld(32'h1010, 32'hDEADBEEF, "ram_alias_0x1010");

        // OUT register
        wr(32'h1, 32'h1111_1111);
        wr(A_OUT1, 32'h5);
        expect_now(K_SAL, {32'h5, 32'h0}, "salidas_out1");
        ld(A_OUT1, 32'h5, "readback_out1");
        ld(32'h1, 32'h1111_1111, "ram_word1_intact");
        wr(A_OUT0, 32'hCAFE);
        expect_now(K_SAL, {32'h5, 32'hCAFE}, "salidas_out0");

        // IN synchroniser latency and flag set
        entradas[31:0] = 32'hA5;
        ld(A_IN0, 32'h0, "in0_t0");
        ld(A_FLAG, 32'h0, "flag_t1");
        ld(A_IN0, 32'hA5, "in0_t2");
        ld(A_FLAG, 32'h1, "flag_t3");
        ld(A_FLAG, 32'h1, "flag_sticky");
        wr(A_FLAG, 32'h1);
        ld(A_FLAG, 32'h0, "flag_cleared");

        // Event and clear of bit1 in the same cycle: set wins
        entradas[63:32] = 32'h3C;
        cyc();
        cyc();
        wr(A_FLAG, 32'h2);
        ld(A_FLAG, 32'h2, "flag_set_wins");
        ld(A_IN1, 32'h3C, "in1_value");
        wr(A_FLAG, 32'h2);
        ld(A_FLAG, 32'h0, "flag1_cleared");

        // Unmapped window, IN write ignored, MASK presence
        wr(32'h300, 32'hABCD0123);
        wr(A_UNM, 32'h77);
        ld(A_UNM, 32'h0, "unmapped_read");
        ld(32'h300, 32'hABCD0123, "ram_0x300_intact");
        expect_now(K_SAL, {32'h5, 32'hCAFE}, "salidas_after_unmapped");
        wr(A_IN0, 32'h99);
        ld(A_IN0, 32'hA5, "in0_write_ignored");
        wr(A_MASK, 32'h1);
        ld(A_MASK, IRQ_EN ? 32'h1 : 32'h0, "mask_readback");

        // irq from masked channel 0
        entradas[31:0] = 32'h5A;
        repeat (4) cyc();
        expect_now(K_IRQ, {63'h0, IRQ_EN}, "irq_after_ch0_event");
        ld(A_FLAG, 32'h1, "flag_before_reset");

        // Reset with a concurrent RAM store
        rst = 1'b1;
        bus.we = 1'b1; bus.addr = 32'h20; bus.wd = 32'h1234_5678;
        cyc();
        rst = 1'b0;
        bus.we = 1'b0;
        expect_now(K_SAL, 64'h0, "salidas_after_reset");
        ld(A_FLAG, 32'h0, "flags_after_reset");
        expect_now(K_IRQ, 64'h0, "irq_after_reset");
        ld(A_MASK, 32'h0, "mask_after_reset");
        ld(32'h10, 32'hDEADBEEF, "ram_kept_through_reset");
        ld(32'h20, 32'h1234_5678, "ram_store_during_reset");
        ld(A_FLAG, 32'h3, "flags_rise_after_reset");

        cyc();
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
